// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging NUM_CH client command/write/read streams onto one memory port.
// A FIFO of {channel, length} tags routes read bursts back to their requesters in issue order.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_cmd_valid,
  output logic [NUM_CH-1:0]        ch_cmd_ready,
  input  logic [NUM_CH-1:0]        ch_cmd_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_cmd_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_cmd_len,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH-1:0]        ch_wvalid,
  output logic [NUM_CH-1:0]        ch_wready,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_rvalid,
  input  logic [NUM_CH-1:0]        ch_rready,
  output logic                     mem_cmd_valid,
  input  logic                     mem_cmd_ready,
  output logic                     mem_cmd_write,
  output logic [ADDR_W-1:0]        mem_cmd_addr,
  output logic [LEN_W-1:0]         mem_cmd_len,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_wvalid,
  input  logic                     mem_wready,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid,
  output logic                     mem_rready,
  output logic                     err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAG_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = TAG_W + 1;
  localparam logic [CH_W-1:0]   LAST_RST = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(TAG_DEPTH);
  localparam logic [NUM_CH-1:0] ONE_CH   = NUM_CH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WDATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    wcnt_q, wcnt_d;

  logic [CH_W-1:0]   tag_ch_q  [TAG_DEPTH];
  logic [CH_W-1:0]   tag_ch_d  [TAG_DEPTH];
  logic [LEN_W-1:0]  tag_len_q [TAG_DEPTH];
  logic [LEN_W-1:0]  tag_len_d [TAG_DEPTH];
  logic [TAG_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W:0]    rcnt_q, rcnt_d;
  logic              err_q, err_d;

  logic              pick_found_s;
  logic [CH_W-1:0]   pick_s;
  logic              full_s, empty_s;
  logic              cmd_valid_s, cmd_fire_s, push_s;
  logic              wfire_s, rfire_s, pop_s, wdata_act_s;
  logic [CH_W-1:0]   head_ch_s;
  logic [LEN_W-1:0]  head_len_s;

  assign full_s      = (cnt_q == FULL_CNT);
  assign empty_s     = (cnt_q == '0);
  // Fullness uses the registered count, so a pop in the same cycle does not unblock a read.
  assign cmd_valid_s = (state_q == S_ISSUE) && (wr_q || !full_s);
  assign cmd_fire_s  = cmd_valid_s && mem_cmd_ready;
  assign push_s      = cmd_fire_s && !wr_q;
  assign wdata_act_s = (state_q == S_WDATA);
  assign wfire_s     = wdata_act_s && ch_wvalid[gnt_q] && mem_wready;
  assign head_ch_s   = tag_ch_q[rptr_q];
  assign head_len_s  = tag_len_q[rptr_q];
  assign rfire_s     = !empty_s && mem_rvalid && ch_rready[head_ch_s];
  assign pop_s       = rfire_s && (rcnt_q == {1'b0, head_len_s});

  // Round-robin pick: scan from lowest to highest priority so the last hit wins.
  always_comb begin
    pick_found_s = 1'b0;
    pick_s       = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      logic [CH_W-1:0] idx;
      idx          = CH_W'((int'(last_q) + i) % NUM_CH);
      pick_s       = ch_cmd_valid[idx] ? idx : pick_s;
      pick_found_s = pick_found_s | ch_cmd_valid[idx];
    end
  end

  // Command FSM next state and latched command fields.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found_s) begin
          state_d = S_ISSUE;
          gnt_d   = pick_s;
          last_d  = pick_s;
          wr_d    = ch_cmd_write[pick_s];
          addr_d  = ch_cmd_addr[pick_s*ADDR_W +: ADDR_W];
          len_d   = ch_cmd_len[pick_s*LEN_W +: LEN_W];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cmd_fire_s) begin
          state_d = wr_q ? S_WDATA : S_IDLE;
          wcnt_d  = '0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WDATA: begin
        if (wfire_s && (wcnt_q == {1'b0, len_q})) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (wfire_s) begin
          wcnt_d  = wcnt_q + {{LEN_W{1'b0}}, 1'b1};
        end else begin
          wcnt_d  = wcnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tag FIFO and read-return beat counter; push and pop may coincide.
  always_comb begin
    tag_ch_d  = tag_ch_q;
    tag_len_d = tag_len_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    if (push_s) begin
      tag_ch_d[wptr_q]  = gnt_q;
      tag_len_d[wptr_q] = len_q;
      wptr_d            = wptr_q + {{(TAG_W-1){1'b0}}, 1'b1};
    end else begin
      wptr_d            = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + {{(TAG_W-1){1'b0}}, 1'b1};
      rcnt_d = '0;
    end else if (rfire_s) begin
      rcnt_d = rcnt_q + {{LEN_W{1'b0}}, 1'b1};
    end else begin
      rcnt_d = rcnt_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + {{TAG_W{1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{TAG_W{1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (empty_s & mem_rvalid);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      last_q    <= LAST_RST;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      tag_ch_q  <= '{default: '0};
      tag_len_q <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      tag_ch_q  <= tag_ch_d;
      tag_len_q <= tag_len_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      err_q     <= err_d;
    end
  end

  assign mem_cmd_valid = cmd_valid_s;
  assign mem_cmd_write = wr_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_len   = len_q;
  assign ch_cmd_ready  = cmd_fire_s ? (ONE_CH << gnt_q) : '0;

  assign mem_wdata     = wdata_act_s ? ch_wdata[gnt_q*DATA_W +: DATA_W] : '0;
  assign mem_wvalid    = wdata_act_s && ch_wvalid[gnt_q];
  assign ch_wready     = (wdata_act_s && mem_wready) ? (ONE_CH << gnt_q) : '0;

  // Read return is combinational; gated by reset_n so every output is low while reset is held.
  assign mem_rready    = reset_n && (empty_s || ch_rready[head_ch_s]);
  assign ch_rvalid     = (reset_n && !empty_s && mem_rvalid) ? (ONE_CH << head_ch_s) : '0;
  assign ch_rdata      = (reset_n && !empty_s) ? mem_rdata : '0;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: client/memory models drive traffic,
// a monitor checks every cycle against per-channel expectation queues.
`timescale 1ns/1ps

module tb_mem_port_arbiter;
  localparam int NUM_CH = 4, ADDR_W = 28, DATA_W = 32, LEN_W = 8, TAG_DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [NUM_CH-1:0]        ch_cmd_valid, ch_cmd_ready, ch_cmd_write;
  logic [NUM_CH*ADDR_W-1:0] ch_cmd_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_cmd_len;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_wvalid, ch_wready, ch_rvalid, ch_rready;
  logic [DATA_W-1:0]        ch_rdata, mem_wdata, mem_rdata;
  logic                     mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [ADDR_W-1:0]        mem_cmd_addr;
  logic [LEN_W-1:0]         mem_cmd_len;
  logic                     mem_wvalid, mem_wready, mem_rvalid, mem_rready, err;

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                     .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(ch_cmd_ready), .ch_cmd_write(ch_cmd_write),
    .ch_cmd_addr(ch_cmd_addr), .ch_cmd_len(ch_cmd_len), .ch_wdata(ch_wdata),
    .ch_wvalid(ch_wvalid), .ch_wready(ch_wready), .ch_rdata(ch_rdata),
    .ch_rvalid(ch_rvalid), .ch_rready(ch_rready),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len), .mem_wdata(mem_wdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len; } cmd_t;
  typedef struct { int ch; int len; } burst_t;
  typedef struct { logic [ADDR_W-1:0] addr; int len; } mrd_t;

  cmd_t              cq[NUM_CH][$];       // client command queues (stimulus)
  cmd_t              exp_cmd[NUM_CH][$];  // expected commands at memory side, per channel
  logic [DATA_W-1:0] wq[NUM_CH][$];       // client write beats still to present
  logic [DATA_W-1:0] exp_wr[NUM_CH][$];   // expected memory write beats, per channel
  logic [DATA_W-1:0] exp_rd[NUM_CH][$];   // expected returned read beats, per channel
  mrd_t              mem_rd_q[$];         // memory model: read bursts to return
  burst_t            out_q[$];            // reference: outstanding bursts in issue order
  int                gnt_log[$];
  int mem_rbeat = 0, rbeat = 0, wr_ch = 0, wr_left = 0, rd_cmds = 0, wr_acc = 0;
  int checks = 0, errors = 0;
  int pct = 100, rr_pct = 100;
  bit err_m = 1'b0, in_rst = 1'b1, hold_r = 1'b0, stray = 1'b0, wtoggle = 1'b0;

  function automatic logic [DATA_W-1:0] rd_pat(logic [ADDR_W-1:0] a, int k);
    logic [ADDR_W-1:0] s;
    s = a + ADDR_W'(k);
    return {4'hD, s};
  endfunction

  function automatic bit rnd(int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_cmd(input int c, input bit wr, input logic [ADDR_W-1:0] a,
                         input int len, input bit pat, input logic [DATA_W-1:0] base);
    cmd_t e;
    e.wr = wr; e.addr = a; e.len = LEN_W'(len);
    cq[c].push_back(e);
    exp_cmd[c].push_back(e);
    for (int k = 0; k <= len; k++) begin
      logic [DATA_W-1:0] d;
      if (wr) begin
        d = pat ? base + DATA_W'(k) : DATA_W'($urandom);
        wq[c].push_back(d);
        exp_wr[c].push_back(d);
      end else begin
        exp_rd[c].push_back(rd_pat(a, k));
      end
    end
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (out_q.size() == 0) && (mem_rd_q.size() == 0) && (wr_left == 0);
    for (int c = 0; c < NUM_CH; c++)
      idle = idle && (cq[c].size() == 0) && (wq[c].size() == 0) && (exp_cmd[c].size() == 0)
             && (exp_wr[c].size() == 0) && (exp_rd[c].size() == 0);
    return idle;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_%s actual=busy required=idle after %0d cycles", name, n);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_grants(input string name, input int exp_seq[$]);
    check({name, "_count"}, gnt_log.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < gnt_log.size(); i++)
      check({name, "_order"}, gnt_log[i], exp_seq[i]);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, {ch_cmd_ready, ch_wready, ch_rvalid, mem_cmd_valid, mem_cmd_write,
                           mem_wvalid, mem_rready, err}, 64'd0);
    check({name, "_cmd"}, {mem_cmd_addr, mem_cmd_len}, 64'd0);
    check({name, "_data"}, {ch_rdata, mem_wdata}, 64'd0);
  endtask

  // Client and memory models: consume handshakes at negedge, drive new inputs after posedge.
  initial begin
    ch_cmd_valid = '0; ch_cmd_write = '0; ch_cmd_addr = '0; ch_cmd_len = '0;
    ch_wdata = '0; ch_wvalid = '0; ch_rready = '0;
    mem_cmd_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_cmd_valid[c] && ch_cmd_ready[c] && cq[c].size() > 0) void'(cq[c].pop_front());
          if (ch_wvalid[c] && ch_wready[c] && wq[c].size() > 0) void'(wq[c].pop_front());
        end
        if (mem_rvalid && mem_rready && mem_rd_q.size() > 0) begin
          mem_rbeat++;
          if (mem_rbeat > mem_rd_q[0].len) begin
            void'(mem_rd_q.pop_front());
            mem_rbeat = 0;
          end
        end
        if (mem_cmd_valid && mem_cmd_ready && !mem_cmd_write)
          mem_rd_q.push_back('{mem_cmd_addr, int'(mem_cmd_len)});
      end
      @(posedge clk);
      #1;
      if (in_rst) begin
        ch_cmd_valid = '0; ch_wvalid = '0; ch_rready = '0;
        mem_cmd_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          ch_cmd_valid[c] = cq[c].size() > 0;
          if (cq[c].size() > 0) begin
            ch_cmd_write[c] = cq[c][0].wr;
            ch_cmd_addr[c*ADDR_W +: ADDR_W] = cq[c][0].addr;
            ch_cmd_len[c*LEN_W +: LEN_W] = cq[c][0].len;
          end
          ch_wvalid[c] = (wq[c].size() > 0) && rnd(pct);
          ch_wdata[c*DATA_W +: DATA_W] = (wq[c].size() > 0) ? wq[c][0] : DATA_W'($urandom);
          ch_rready[c] = rnd(rr_pct);
        end
        mem_cmd_ready = rnd(pct);
        mem_wready = wtoggle ? ~mem_wready : rnd(pct);
        if (stray) begin
          mem_rvalid = 1'b1;
          mem_rdata = 32'hBAD0_BAD0;
          stray = 1'b0;
        end else if (!hold_r && mem_rd_q.size() > 0 && rnd(pct)) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_pat(mem_rd_q[0].addr, mem_rbeat);
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata = DATA_W'($urandom);
        end
      end
    end
  end

  // Monitor: compares the DUT against the reference queues every cycle.
  initial begin
    int osz, h, c;
    logic [NUM_CH-1:0] exp_v;
    cmd_t e;
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        osz = out_q.size();
        check("err", err, err_m);
        exp_v = (wr_left > 0 && mem_wready) ? (NUM_CH'(1) << wr_ch) : '0;
        check("ch_wready", ch_wready, exp_v);
        check("mem_wvalid", mem_wvalid, (wr_left > 0) ? ch_wvalid[wr_ch] : 1'b0);
        if (mem_wvalid && mem_wready && wr_left > 0) begin
          if (exp_wr[wr_ch].size() == 0) check("wbeat_unexpected", 1, 0);
          else check("mem_wdata", mem_wdata, exp_wr[wr_ch].pop_front());
          wr_left--;
          wr_acc++;
        end
        if (osz == 0) begin
          check("mem_rready_empty", mem_rready, 1'b1);
          check("ch_rvalid_empty", ch_rvalid, 0);
          if (mem_rvalid) err_m = 1'b1;
        end else begin
          h = out_q[0].ch;
          exp_v = mem_rvalid ? (NUM_CH'(1) << h) : '0;
          check("ch_rvalid", ch_rvalid, exp_v);
          check("mem_rready", mem_rready, ch_rready[h]);
          if (mem_rvalid && ch_rready[h]) begin
            if (exp_rd[h].size() == 0) check("rbeat_unexpected", 1, 0);
            else check("ch_rdata", ch_rdata, exp_rd[h].pop_front());
            rbeat++;
            if (rbeat > out_q[0].len) begin
              void'(out_q.pop_front());
              rbeat = 0;
            end
          end
        end
        if (mem_cmd_valid && !mem_cmd_write) check("read_cmd_while_full", osz < TAG_DEPTH, 1'b1);
        if (mem_cmd_valid && mem_cmd_ready) begin
          check("cmd_ready_onehot", $onehot(ch_cmd_ready), 1'b1);
          c = 0;
          for (int i = 0; i < NUM_CH; i++) if (ch_cmd_ready[i]) c = i;
          if (exp_cmd[c].size() == 0) begin
            check("cmd_unexpected", 1, 0);
          end else begin
            e = exp_cmd[c].pop_front();
            check("cmd_fields", {mem_cmd_write, mem_cmd_addr, mem_cmd_len}, {e.wr, e.addr, e.len});
            gnt_log.push_back(c);
            if (e.wr) begin
              wr_ch = c;
              wr_left = int'(e.len) + 1;
            end else begin
              out_q.push_back('{c, int'(e.len)});
              rd_cmds++;
            end
          end
        end else begin
          check("cmd_ready_idle", ch_cmd_ready, 0);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq[$];
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    in_rst = 1'b0;
    @(posedge clk);
    #2;
    check("post_reset_rready", mem_rready, 1'b1);
    check("post_reset_err", err, 1'b0);

    // Four simultaneous reads must be granted 0,1,2,3 after reset.
    gnt_log.delete();
    for (int c = 0; c < NUM_CH; c++) gen_cmd(c, 1'b0, ADDR_W'(16 * (c + 1)), 0, 1'b0, '0);
    wait_drain("rr_reads", 200);
    seq = '{0, 1, 2, 3};
    check_grants("rr_reads", seq);

    // Write burst with toggling mem_wready, then a pending ch0 read.
    gnt_log.delete();
    wtoggle = 1'b1;
    gen_cmd(2, 1'b1, 28'h100, 3, 1'b1, 32'hA0);
    @(posedge clk);
    gen_cmd(0, 1'b0, 28'h200, 0, 1'b0, '0);
    wait_drain("write_burst", 300);
    wtoggle = 1'b0;
    seq = '{2, 0};
    check_grants("write_then_read", seq);

    // Nine reads with no returned data: only eight may issue.
    hold_r = 1'b1;
    rd_cmds = 0;
    for (int i = 0; i < 9; i++) gen_cmd(1, 1'b0, ADDR_W'($urandom), 1, 1'b0, '0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    #1;
    check("full_issued", rd_cmds, 8);
    check("full_cmd_valid", mem_cmd_valid, 1'b0);
    hold_r = 1'b0;
    wait_drain("tag_full", 500);
    check("full_all_issued", rd_cmds, 9);

    // Read burst with back-pressure from the client.
    pct = 100; rr_pct = 40;
    gen_cmd(3, 1'b0, 28'h300, 3, 1'b0, '0);
    wait_drain("rready_stall", 300);

    // Stray read beat with no outstanding burst: sticky error.
    @(posedge clk);
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("err_set", err, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    check("err_sticky", err, 1'b1);

    // Random mixed traffic.
    pct = 70; rr_pct = 70;
    for (int i = 0; i < 120; i++)
      gen_cmd($urandom_range(NUM_CH - 1, 0), 1'($urandom), ADDR_W'($urandom),
              $urandom_range(7, 0), 1'b0, '0);
    wait_drain("random", 20000);

    // Reset during the third write beat, then round-robin restarts at ch0.
    pct = 100;
    wr_acc = 0;
    gen_cmd(2, 1'b1, 28'h400, 3, 1'b0, '0);
    for (int n = 0; n < 200 && wr_acc < 2; n++) @(posedge clk);
    check("reset_reached_beat2", wr_acc, 2);
    #3;
    reset_n = 1'b0;
    in_rst = 1'b1;
    #1;
    check_outputs_zero("midburst_reset");
    for (int c = 0; c < NUM_CH; c++) begin
      cq[c].delete(); exp_cmd[c].delete(); wq[c].delete(); exp_wr[c].delete(); exp_rd[c].delete();
    end
    mem_rd_q.delete(); out_q.delete();
    mem_rbeat = 0; rbeat = 0; wr_left = 0; err_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    in_rst = 1'b0;
    @(posedge clk);
    gnt_log.delete();
    for (int c = 0; c < NUM_CH; c++) gen_cmd(c, 1'b0, ADDR_W'(32 * (c + 1)), 1, 1'b0, '0);
    wait_drain("after_reset", 300);
    seq = '{0, 1, 2, 3};
    check_grants("after_reset", seq);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
